// File: rtl/disp_pkg.sv
// disp_pkg: shared definitions for the seven-segment display scheduler.
//   DISP_DIGITS  - digits on the scanner (one nibble each)
//   DISP_DATA_W  - width of one display word
//   disp_state_t - scheduler FSM states
//   disp_max     - elaboration-time max() used to size the hold/gap counter
package disp_pkg;

  localparam int DISP_DIGITS = 4;
  localparam int DISP_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } disp_state_t;

  function automatic int disp_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/disp_rr_pick.sv
// disp_rr_pick: combinational circular first-one finder.
// Ports:
//   req   [N]      request vector
//   ptr   [PTR_W]  index where the circular search starts
//   grant [PTR_W]  first requesting index at or after ptr (wrapping)
//   valid          1 when any request bit is set
module disp_rr_pick #(
  parameter int N     = 3,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] grant,
  output logic             valid
);

  localparam logic [PTR_W:0] N_W = (PTR_W + 1)'(N);

  // Walk the N positions starting at ptr; the first set bit wins.
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W:0]   wrap;
    logic [PTR_W-1:0] idx;
    logic             hit;
    grant = '0;
    valid = 1'b0;
    sum   = '0;
    wrap  = '0;
    idx   = '0;
    hit   = 1'b0;
    for (int k = 0; k < N; k++) begin
      sum   = {1'b0, ptr} + (PTR_W + 1)'(k);
      wrap  = (sum >= N_W) ? (sum - N_W) : sum;
      idx   = wrap[PTR_W-1:0];
      // Only the first hit after ptr may claim the grant.
      hit   = req[idx] & ~valid;
      grant = hit ? idx : grant;
      valid = valid | req[idx];
    end
  end

endmodule

// File: rtl/seven_seg_disp_sched.sv
// seven_seg_disp_sched: shares one 4-digit seven-segment scanner between
// N requesters. Grants round-robin, shows the granted word for HOLD_CYCLES,
// then blanks for GAP_CYCLES before the next arbitration.
// Optional feature macro: DISP_PREEMPT_EN (requester 0 preempts any other owner).
// Ports:
//   clk       clock, all state on posedge
//   rst       synchronous active-high reset
//   req[N]    per-requester request (data held stable while set)
//   data      requester i word at data[16*i +: 16]
//   ack[N]    one-cycle pulse on the grant edge
//   dispData  word driven to the scanner
//   dispBlank 1 = scanner blanked
//   owner     index of the last granted requester
//   busy      1 while in SHOW or GAP
module seven_seg_disp_sched
  import disp_pkg::*;
#(
  parameter int N           = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             req,
  input  logic [DISP_DATA_W*N-1:0] data,
  output logic [N-1:0]             ack,
  output logic [DISP_DATA_W-1:0]   dispData,
  output logic                     dispBlank,
  output logic [$clog2(N)-1:0]     owner,
  output logic                     busy
);

  localparam int PTR_W = $clog2(N);
  localparam int CNT_W = $clog2(disp_max(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  disp_state_t            state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [PTR_W-1:0]       ptr, ptr_nxt;
  logic [N-1:0]           ack_nxt;
  logic [DISP_DATA_W-1:0] data_nxt;
  logic                   blank_nxt;
  logic [PTR_W-1:0]       owner_nxt;
  logic                   busy_nxt;

  logic [PTR_W-1:0]       pick_grant;
  logic                   pick_valid;
  logic                   preempt;

  disp_rr_pick #(.N(N), .PTR_W(PTR_W)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (pick_grant),
    .valid (pick_valid)
  );

`ifdef DISP_PREEMPT_EN
  // Requester 0 may cut in on any other owner while a word is shown or blanked.
  assign preempt = (state != IDLE) && req[0] && (owner != '0);
`else
  assign preempt = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= '0;
      ack       <= '0;
      dispData  <= '0;
      dispBlank <= 1'b1;
      owner     <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ptr       <= ptr_nxt;
      ack       <= ack_nxt;
      dispData  <= data_nxt;
      dispBlank <= blank_nxt;
      owner     <= owner_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_valid) state_nxt = SHOW;
        else            state_nxt = IDLE;
      end
      SHOW: begin
        if (preempt)          state_nxt = SHOW;
        else if (cnt == '0)   state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
        else                  state_nxt = SHOW;
      end
      GAP: begin
        if (preempt)          state_nxt = SHOW;
        else if (cnt == '0)   state_nxt = IDLE;
        else                  state_nxt = GAP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of counter, pointer and the registered outputs.
  always_comb begin
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    ack_nxt   = '0;
    data_nxt  = dispData;
    blank_nxt = dispBlank;
    owner_nxt = owner;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          ack_nxt[pick_grant] = 1'b1;
          data_nxt  = data[DISP_DATA_W*int'(pick_grant) +: DISP_DATA_W];
          blank_nxt = 1'b0;
          owner_nxt = pick_grant;
          ptr_nxt   = (pick_grant == PTR_W'(N - 1)) ? '0 : (pick_grant + PTR_W'(1));
          cnt_nxt   = HOLD_LOAD;
        end else begin
          // Nothing requested: the last word (or reset blank) stays on the bus.
          ack_nxt = '0;
        end
      end
      SHOW: begin
        if (preempt) begin
          ack_nxt[0] = 1'b1;
          data_nxt   = data[DISP_DATA_W-1:0];
          blank_nxt  = 1'b0;
          owner_nxt  = '0;
          cnt_nxt    = HOLD_LOAD;
        end else if (cnt == '0) begin
          if (GAP_CYCLES > 0) begin
            blank_nxt = 1'b1;
            cnt_nxt   = GAP_LOAD;
          end else begin
            blank_nxt = dispBlank;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (preempt) begin
          ack_nxt[0] = 1'b1;
          data_nxt   = data[DISP_DATA_W-1:0];
          blank_nxt  = 1'b0;
          owner_nxt  = '0;
          cnt_nxt    = HOLD_LOAD;
        end else if (cnt == '0) begin
          // Leaving the gap unblanks so the last word reappears in IDLE.
          blank_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        ack_nxt = '0;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_seven_seg_disp_sched.sv
// Self-checking bench for seven_seg_disp_sched (N=3, HOLD=4, GAP=2) plus a
// second instance with HOLD=1, GAP=0. A behavioural model tracks "cycles
// left until idle" and checks the main instance every cycle; directed
// literal checks pin specific cycles of both instances.
module tb_seven_seg_disp_sched;

  localparam int N = 3;
  localparam int H = 4;
  localparam int G = 2;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [47:0] data;
  logic [2:0]  ack;
  logic [15:0] dispData;
  logic        dispBlank;
  logic [1:0]  owner;
  logic        busy;

  logic [2:0]  req_b;
  logic [47:0] data_b;
  logic [2:0]  ack_b;
  logic [15:0] disp_data_b;
  logic        blank_b;
  logic [1:0]  owner_b;
  logic        busy_b;

  int compared   = 0;
  int mismatched = 0;

  seven_seg_disp_sched #(.N(N), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack),
    .dispData(dispData), .dispBlank(dispBlank), .owner(owner), .busy(busy)
  );

  seven_seg_disp_sched #(.N(3), .HOLD_CYCLES(1), .GAP_CYCLES(0)) dut2 (
    .clk(clk), .rst(rst), .req(req_b), .data(data_b), .ack(ack_b),
    .dispData(disp_data_b), .dispBlank(blank_b), .owner(owner_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: a grant starts H+G busy cycles; the last G are blank.
  logic [15:0] m_data;
  logic        m_blank;
  logic [2:0]  m_ack;
  int          m_owner;
  int          m_ptr;
  int          m_left;
  bit          m_valid = 1'b0;
  int          m_g;
  bit          m_hit;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_data = 16'h0000; m_blank = 1'b1; m_ack = 3'b000;
      m_owner = 0; m_ptr = 0; m_left = 0; m_valid = 1'b1;
    end else begin
      m_ack = 3'b000;
      if (m_left == 0) begin
        m_hit = 1'b0; m_g = 0;
        for (int k = 0; k < N; k++) begin
          if (!m_hit && req[(m_ptr + k) % N]) begin
            m_hit = 1'b1;
            m_g = (m_ptr + k) % N;
          end
        end
        if (m_hit) begin
          m_ack[m_g] = 1'b1;
          m_data  = data[16*m_g +: 16];
          m_blank = 1'b0;
          m_owner = m_g;
          m_ptr   = (m_g + 1) % N;
          m_left  = H + G;
        end
`ifdef DISP_PREEMPT_EN
      end else if (req[0] && m_owner != 0) begin
        m_ack[0] = 1'b1;
        m_data   = data[15:0];
        m_blank  = 1'b0;
        m_owner  = 0;
        m_left   = H + G;
`endif
      end else begin
        m_left  = m_left - 1;
        m_blank = (m_left != 0) && (m_left <= G);
      end
    end
  end

  // Every-cycle comparison of the main instance against the model.
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("model_data",  dispData,  m_data);
      chk("model_blank", dispBlank, m_blank);
      chk("model_ack",   ack,       m_ack);
      chk("model_owner", owner,     m_owner);
      chk("model_busy",  busy,      (m_left != 0));
    end
  end

  logic [15:0] words [3];
  logic [2:0]  tab_ack [6];

  initial begin
    words[0] = 16'hAAAA; words[1] = 16'hBBBB; words[2] = 16'hCCCC;
`ifdef DISP_PREEMPT_EN
    tab_ack[0] = 3'b001; tab_ack[1] = 3'b000; tab_ack[2] = 3'b010;
    tab_ack[3] = 3'b001; tab_ack[4] = 3'b000; tab_ack[5] = 3'b001;
`else
    tab_ack[0] = 3'b001; tab_ack[1] = 3'b000; tab_ack[2] = 3'b010;
    tab_ack[3] = 3'b000; tab_ack[4] = 3'b001; tab_ack[5] = 3'b000;
`endif
    rst = 1'b1; req = 3'b000; data = 48'h0; req_b = 3'b000; data_b = 48'h0;

    // 1. Reset for two cycles.
    repeat (2) @(negedge clk);
    chk("rst_blank", dispBlank, 1'b1);
    chk("rst_data",  dispData,  16'h0000);
    chk("rst_ack",   ack,       3'b000);
    chk("rst_busy",  busy,      1'b0);
    chk("rst_owner", owner,     2'd0);
    chk("rst_blank_b", blank_b, 1'b1);

    // 2. Single request from requester 1.
    rst = 1'b0;
    data[31:16] = 16'h1234;
    req = 3'b010;
    @(negedge clk);
    chk("t1_ack",   ack,       3'b010);
    chk("t1_data",  dispData,  16'h1234);
    chk("t1_blank", dispBlank, 1'b0);
    chk("t1_owner", owner,     2'd1);
    req = 3'b000;
    repeat (3) @(negedge clk);
    chk("t4_blank", dispBlank, 1'b0);
    chk("t4_busy",  busy,      1'b1);
    @(negedge clk);
    chk("t5_blank", dispBlank, 1'b1);
    @(negedge clk);
    chk("t6_blank", dispBlank, 1'b1);
    @(negedge clk);
    chk("t7_blank", dispBlank, 1'b0);
    chk("t7_data",  dispData,  16'h1234);
    chk("t7_busy",  busy,      1'b0);

    // 3. Round-robin with all three requesting.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    data = {16'hCCCC, 16'hBBBB, 16'hAAAA};
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      repeat ((k == 0) ? 1 : 7) @(negedge clk);
      chk("rr_ack",  ack,      3'b001 << (k % 3));
      chk("rr_data", dispData, words[k % 3]);
    end
    req = 3'b000;
    repeat (7) @(negedge clk);

    // 4. Reset in the middle of SHOW; re-grant restarts at requester 0.
    req = 3'b010;
    @(negedge clk);
    chk("mid_ack", ack, 3'b010);
    rst = 1'b1;
    req = 3'b111;
    @(negedge clk);
    chk("mid_rst_ack",   ack,       3'b000);
    chk("mid_rst_blank", dispBlank, 1'b1);
    chk("mid_rst_data",  dispData,  16'h0000);
    chk("mid_rst_busy",  busy,      1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("regrant_ack",  ack,      3'b001);
    chk("regrant_data", dispData, 16'hAAAA);
    req = 3'b000;
    repeat (7) @(negedge clk);

    // 5. Requester 0 arrives while requester 2 owns the display.
    req = 3'b100;
    @(negedge clk);
    chk("pre_own_ack",   ack,   3'b100);
    chk("pre_own_owner", owner, 2'd2);
    data[15:0] = 16'h0F0F;
    req = 3'b001;
    @(negedge clk);
`ifdef DISP_PREEMPT_EN
    chk("preempt_ack",   ack,      3'b001);
    chk("preempt_data",  dispData, 16'h0F0F);
    chk("preempt_owner", owner,    2'd0);
    @(negedge clk);
    chk("no_repreempt_ack", ack, 3'b000);
`else
    chk("no_preempt_ack",  ack,      3'b000);
    chk("no_preempt_data", dispData, 16'hCCCC);
    repeat (5) @(negedge clk);
    chk("gap_end_ack",   ack,       3'b000);
    chk("gap_end_blank", dispBlank, 1'b0);
    @(negedge clk);
    chk("late_ack",  ack,      3'b001);
    chk("late_data", dispData, 16'h0F0F);
`endif
    req = 3'b000;
    repeat (7) @(negedge clk);

    // 6. HOLD=1, GAP=0 instance alternating between requesters 0 and 1.
    data_b = {16'h0000, 16'h2222, 16'h1111};
    req_b = 3'b011;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      chk("fast_ack",   ack_b,   tab_ack[t]);
      chk("fast_blank", blank_b, 1'b0);
      if (tab_ack[t] != 3'b000)
        chk("fast_data", disp_data_b, (tab_ack[t] == 3'b001) ? 16'h1111 : 16'h2222);
    end
    req_b = 3'b000;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
